// File: rtl/mul_div_unit.sv
// mul_div_unit: 64-bit iterative radix-2 multiply/divide unit (MUL, UMULH, UDIV, SDIV).
// Divide datapath present only when MDU_DIV_EN is defined.
module mul_div_unit #(
    parameter int WIDTH = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] OPERAND_A,
    input  logic [WIDTH-1:0] OPERAND_B,
    input  logic [4:0]       DEST_REG,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [4:0]       RESULT_REG,
    output logic             WRITE_ENABLE
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             legal_q, legal_d;
    logic [1:0]       op_q, op_d;
    logic [4:0]       dest_q, dest_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       result_reg_q, result_reg_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] fin_res;
`ifdef MDU_DIV_EN
    logic             neg_q, neg_d;
    logic [WIDTH:0]   div_r, div_diff;
    logic             div_ok;
`endif

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
`ifdef MDU_DIV_EN
        div_r    = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_r - {1'b0, a_q};
        div_ok   = !div_diff[WIDTH];
        fin_res  = op_q[1] ? (neg_q ? -lo_q : lo_q) : (op_q[0] ? hi_q : lo_q);
`else
        fin_res  = op_q[1] ? '0 : (op_q[0] ? hi_q : lo_q);
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        legal_d      = legal_q;
        op_d         = op_q;
        dest_d       = dest_q;
        a_d          = a_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        result_d     = result_q;
        result_reg_d = result_reg_q;
`ifdef MDU_DIV_EN
        neg_d        = neg_q;
`endif
        if (state_q == RUN) begin
            if (last_q) begin
                state_d      = FIN;
                result_d     = fin_res;
                result_reg_d = dest_q;
            end else begin
                cnt_d  = cnt_q + 6'd1;
                last_d = &cnt_q;
`ifdef MDU_DIV_EN
                if (op_q[1]) begin
                    // restoring step: partial remainder in hi, quotient shifts into lo
                    hi_d = div_ok ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], div_ok};
                end else
`endif
                {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            end
        end else if (START) begin
            state_d = RUN;
            cnt_d   = '0;
            last_d  = 1'b0;
            legal_d = 1'b1;
            op_d    = OP;
            dest_d  = DEST_REG;
            a_d     = OPERAND_A;
            hi_d    = '0;
            lo_d    = OPERAND_B;
`ifdef MDU_DIV_EN
            if (OP[1]) begin
                a_d   = (OP[0] && OPERAND_B[WIDTH-1]) ? -OPERAND_B : OPERAND_B;
                lo_d  = (OP[0] && OPERAND_A[WIDTH-1]) ? -OPERAND_A : OPERAND_A;
                neg_d = OP[0] & (OPERAND_A[WIDTH-1] ^ OPERAND_B[WIDTH-1]);
                if (OPERAND_B == '0) begin
                    state_d      = FIN;
                    result_d     = '0;
                    result_reg_d = DEST_REG;
                end
            end
`else
            if (OP[1]) begin
                state_d      = FIN;
                legal_d      = 1'b0;
                result_d     = '0;
                result_reg_d = DEST_REG;
            end
`endif
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            legal_q      <= 1'b0;
            op_q         <= '0;
            dest_q       <= '0;
            a_q          <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            result_q     <= '0;
            result_reg_q <= '0;
`ifdef MDU_DIV_EN
            neg_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            legal_q      <= legal_d;
            op_q         <= op_d;
            dest_q       <= dest_d;
            a_q          <= a_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            result_q     <= result_d;
            result_reg_q <= result_reg_d;
`ifdef MDU_DIV_EN
            neg_q        <= neg_d;
`endif
        end
    end

    assign BUSY         = state_q == RUN;
    assign DONE         = state_q == FIN;
    assign WRITE_ENABLE = DONE && legal_q;
    assign RESULT       = result_q;
    assign RESULT_REG   = result_reg_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [63:0] OPERAND_A = '0;
    logic [63:0] OPERAND_B = '0;
    logic [4:0]  DEST_REG = '0;
    logic        BUSY, DONE, WRITE_ENABLE;
    logic [63:0] RESULT;
    logic [4:0]  RESULT_REG;
    int          n_checks = 0;
    int          n_fail = 0;

    localparam logic [1:0] MUL = 2'b00, UMULH = 2'b01, UDIV = 2'b10, SDIV = 2'b11;

    mul_div_unit #(.WIDTH(64)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP),
        .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .DEST_REG(DEST_REG),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .RESULT_REG(RESULT_REG),
        .WRITE_ENABLE(WRITE_ENABLE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] dst);
        START = 1'b1;
        OP = op;
        OPERAND_A = a;
        OPERAND_B = b;
        DEST_REG = dst;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] dst);
        @(negedge CLK);
        drive(op, a, b, dst);
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    // lat counts clock edges from the current one until DONE is visible
    task automatic wait_done(input string tag, input int lat, input logic [63:0] res,
                             input logic [4:0] dst, input logic we);
        int k = 0;
        @(negedge CLK);
        while (!DONE && k < 200) begin
            @(posedge CLK);
            k++;
            @(negedge CLK);
        end
        check({tag, "_lat"}, 64'(k), 64'(lat));
        check({tag, "_res"}, RESULT, res);
        check({tag, "_reg"}, 64'(RESULT_REG), 64'(dst));
        check({tag, "_we"}, 64'(WRITE_ENABLE), 64'(we));
        check({tag, "_busy"}, 64'(BUSY), 64'd0);
    endtask

    task automatic op_test(input string tag, input logic [1:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] dst, input int lat,
                           input logic [63:0] res, input logic we);
        start_op(op, a, b, dst);
        wait_done(tag, lat, res, dst, we);
        @(negedge CLK);
        check({tag, "_done_pulse"}, 64'(DONE), 64'd0);
        check({tag, "_we_pulse"}, 64'(WRITE_ENABLE), 64'd0);
        check({tag, "_hold"}, RESULT, res);
    endtask

    initial begin
        int hits;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_we", 64'(WRITE_ENABLE), 64'd0);
        check("rst_result", RESULT, 64'd0);
        check("rst_reg", 64'(RESULT_REG), 64'd0);
        RST = 1'b0;

        start_op(MUL, 64'h000A, 64'h0005, 5'd7);
        @(negedge CLK);
        check("mul_busy", 64'(BUSY), 64'd1);
        wait_done("mul_10x5", 64, 64'h32, 5'd7, 1'b1);
        @(negedge CLK);
        check("mul_done_pulse", 64'(DONE), 64'd0);
        check("mul_we_pulse", 64'(WRITE_ENABLE), 64'd0);
        check("mul_hold", RESULT, 64'h32);

        op_test("umulh_ones", UMULH, '1, '1, 5'd1, 65, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        op_test("mul_ones", MUL, '1, '1, 5'd2, 65, 64'h1, 1'b1);
        op_test("mul_neg", MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd3, 65, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
        op_test("umulh_2p65", UMULH, 64'h8000_0000_0000_0000, 64'd4, 5'd4, 65, 64'h2, 1'b1);
        op_test("umulh_2p64", UMULH, 64'h1_0000_0000, 64'h1_0000_0000, 5'd5, 65, 64'h1, 1'b1);
        op_test("mul_2p64", MUL, 64'h1_0000_0000, 64'h1_0000_0000, 5'd6, 65, 64'h0, 1'b1);

`ifdef MDU_DIV_EN
        op_test("sdiv_m7_2", SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 65, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        op_test("udiv_ffff_5", UDIV, 64'hFFFF, 64'd5, 5'd9, 65, 64'h3333, 1'b1);
        op_test("udiv_zero", UDIV, 64'h1234, 64'd0, 5'd10, 0, 64'h0, 1'b1);
        op_test("sdiv_min_m1", SDIV, 64'h8000_0000_0000_0000, '1, 5'd11, 65, 64'h8000_0000_0000_0000, 1'b1);
        op_test("sdiv_7_m2", SDIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd12, 65, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        op_test("sdiv_m100_7", SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd13, 65, 64'hFFFF_FFFF_FFFF_FFF2, 1'b1);
        op_test("udiv_big_3", UDIV, 64'h8000_0000_0000_0000, 64'd3, 5'd14, 65, 64'h2AAA_AAAA_AAAA_AAAA, 1'b1);
        op_test("sdiv_zero", SDIV, 64'd5, 64'd0, 5'd15, 0, 64'h0, 1'b1);
`else
        op_test("udiv_off", UDIV, 64'hFFFF, 64'd5, 5'd8, 0, 64'h0, 1'b0);
        op_test("sdiv_off", SDIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 0, 64'h0, 1'b0);
`endif

        start_op(MUL, 64'h000A, 64'h0005, 5'd3);
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        drive(MUL, 64'd99, 64'd99, 5'd9);
        @(posedge CLK);
        #1 START = 1'b0;
        wait_done("start_in_run", 55, 64'h32, 5'd3, 1'b1);

        @(negedge CLK);
        drive(MUL, 64'd3, 64'd4, 5'd1);
        @(posedge CLK);
        #1 drive(MUL, 64'd6, 64'd7, 5'd2);
        wait_done("b2b_first", 65, 64'd12, 5'd1, 1'b1);
        @(posedge CLK);
        #1 START = 1'b0;
        wait_done("b2b_second", 65, 64'd42, 5'd2, 1'b1);

        start_op(MUL, 64'h000A, 64'h0005, 5'd5);
        repeat (29) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_result", RESULT, 64'd0);
        check("abort_reg", 64'(RESULT_REG), 64'd0);
        hits = 0;
        repeat (100) begin
            @(negedge CLK);
            if (DONE || WRITE_ENABLE) hits++;
        end
        check("abort_no_done", 64'(hits), 64'd0);

        op_test("post_reset_mul", MUL, 64'd7, 64'd6, 5'd31, 65, 64'd42, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width; only 64 is supported.
REQ-002 Port: CLK  in  1  system clock; all state changes on posedge CLK.
REQ-003 Port: RST  in  1  reset, synchronous, active-high.
REQ-004 Port: START  in  1  request; sampled only when not BUSY.
REQ-005 Port: OP  in  2  00 MUL (low 64 of product), 01 UMULH (high 64, unsigned), 10 UDIV, 11 SDIV.
REQ-006 Port: OPERAND_A  in  64  first operand, fed from register-file read port A.
REQ-007 Port: OPERAND_B  in  64  second operand (multiplier/divisor), fed from read port B.
REQ-008 Port: DEST_REG  in  5  destination register index carried with the request.
REQ-009 Port: BUSY  out  1  high while an operation is in flight.
REQ-010 Port: DONE  out  1  one-cycle completion pulse.
REQ-011 Port: RESULT  out  64  result; drives register-file WRITE_DATA.
REQ-012 Port: RESULT_REG  out  5  captured DEST_REG; drives register-file WRITE_REG.
REQ-013 Port: WRITE_ENABLE  out  1  drives register-file REG_WRITE_ENABLE; high only in the DONE cycle of a legal operation.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and FIN; BUSY=1 in RUN, and DONE=1 in FIN only.
REQ-015 IDLE or FIN with START=1: operands, OP and DEST_REG SHALL be captured, the 6-bit iteration counter cleared, and the next state SHALL be RUN.
REQ-016 START while in RUN SHALL be ignored; captured operands SHALL NOT change.
REQ-017 RUN SHALL perform one radix-2 iteration per cycle (shift-add for MUL/UMULH, restoring shift-subtract for divide) and exit to FIN after exactly 64 iterations.
REQ-018 Latency: START high at edge t means DONE=1 during the cycle after edge t+65; DONE and WRITE_ENABLE SHALL last exactly one cycle.
REQ-019 MUL SHALL return bits [63:0] of the 128-bit product (identical for signed and unsigned).
REQ-020 UMULH SHALL return bits [127:64] of the unsigned 128-bit product.
REQ-021 UDIV SHALL return the unsigned quotient; the remainder SHALL be discarded.
REQ-022 SDIV SHALL divide magnitudes, truncate toward zero, and negate the quotient when the operand signs differ.
REQ-023 SDIV of 0x8000_0000_0000_0000 by -1 SHALL return 0x8000_0000_0000_0000 without error.
REQ-024 Divide by zero (UDIV/SDIV, OPERAND_B=0) SHALL skip RUN, go directly to FIN with RESULT=0 and WRITE_ENABLE=1, and assert DONE in the cycle after the START edge.
REQ-025 RESULT and RESULT_REG SHALL hold their last values until the next completion or reset; only DONE/WRITE_ENABLE pulse.
REQ-026 START in FIN SHALL be accepted (back-to-back), with FIN lasting exactly one cycle.

Reset
REQ-027 RST=1 at a clock edge SHALL force state IDLE, counter 0, BUSY=0, DONE=0, WRITE_ENABLE=0, RESULT=0 and RESULT_REG=0.
REQ-028 RST SHALL take priority over START; a reset during RUN SHALL abort the operation, and no DONE SHALL follow.

Configuration
REQ-029 The macro MDU_DIV_EN SHALL enable the divide datapath; with it defined, UDIV/SDIV behave as in REQ-021..REQ-024.
REQ-030 Without MDU_DIV_EN, no divide logic SHALL exist; a START with OP[1]=1 SHALL go to FIN in one cycle with DONE=1, RESULT=0 and WRITE_ENABLE=0.

Verification
REQ-031 Check: MUL with A=0x000A, B=0x0005, DEST_REG=7 -> DONE 65 cycles after START, RESULT=0x32, RESULT_REG=7, WRITE_ENABLE=1 for one cycle.
REQ-032 Check: UMULH with A=B=0xFFFF_FFFF_FFFF_FFFF -> RESULT=0xFFFF_FFFF_FFFF_FFFE; the same operands with MUL -> RESULT=0x1.
REQ-033 Check: SDIV with A=-7, B=2 -> RESULT=-3 (0xFFFF_FFFF_FFFF_FFFD); UDIV with A=0xFFFF, B=0x0005 -> RESULT=0x3333.
REQ-034 Check: UDIV with B=0 -> DONE in the cycle after START, RESULT=0; SDIV with A=0x8000_0000_0000_0000, B=-1 -> RESULT=0x8000_0000_0000_0000.
REQ-035 Check: START pulsed again at RUN iteration 10 -> ignored, original result correct; START held in FIN -> second operation completes 65 cycles later.
REQ-036 Check: RST asserted at RUN iteration 30 -> next cycle BUSY=0 and RESULT=0, and no DONE/WRITE_ENABLE for 100 cycles; MDU_DIV_EN undefined with OP=10 -> DONE with WRITE_ENABLE=0.
